mpu_store_stream: RTL and testbench

Parametrised successor of the matrix store unit: moves an M×N matrix from the register file to external memory one element per beat, in row-major or transposed (column-major) order. Adds valid/ready backpressure on the memory side, a 1-cycle-latency register-file read path, a 2-entry output buffer, last/done/busy signalling, and zero-size handling. Sits between the MPU register file and the memory interface, driven by the MPU controller.

---
 rtl/mpu_store_stream_if.sv | 56 +++++
 rtl/mpu_store_stream.sv | 153 +++++++++++++++
 tb/tb_mpu_store_stream.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_store_stream_if.sv
// Bundle of controller, register-file and memory-side signals for the matrix store streamer.
// The master modport is the store unit itself; slave is the surrounding environment.
interface mpu_store_stream_if #(
    parameter int DATA_W = 32,
    parameter int MAX_M  = 8,
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 4
);
    localparam int M_W = $clog2(MAX_M + 1);
    localparam int N_W = $clog2(MAX_N + 1);

    // Controller side
    logic              store_req_in;
    logic              store_transpose_in;
    logic              store_ready_in;
    logic [M_W-1:0]    reg_m_store_size_in;
    logic [N_W-1:0]    reg_n_store_size_in;
    logic              store_busy_out;
    logic              store_done_out;

    // Register-file read path
    logic [DATA_W-1:0] reg_store_element_in;
    logic              reg_store_en_out;
    logic [M_W-1:0]    reg_i_store_loc_out;
    logic [N_W-1:0]    reg_j_store_loc_out;
    logic [ADDR_W-1:0] reg_store_addr_out;

    // Memory stream
    logic [ADDR_W-1:0] mem_store_addr_in;
    logic              mem_store_ready_in;
    logic              mem_store_en_out;
    logic [DATA_W-1:0] mem_store_element_out;
    logic              mem_store_last_out;
    logic [M_W-1:0]    mem_m_store_size_out;
    logic [N_W-1:0]    mem_n_store_size_out;

    modport master (
        input  store_req_in, store_transpose_in, store_ready_in,
        input  reg_m_store_size_in, reg_n_store_size_in, reg_store_element_in,
        input  mem_store_addr_in, mem_store_ready_in,
        output store_busy_out, store_done_out,
        output reg_store_en_out, reg_i_store_loc_out, reg_j_store_loc_out, reg_store_addr_out,
        output mem_store_en_out, mem_store_element_out, mem_store_last_out,
        output mem_m_store_size_out, mem_n_store_size_out
    );

    modport slave (
        output store_req_in, store_transpose_in, store_ready_in,
        output reg_m_store_size_in, reg_n_store_size_in, reg_store_element_in,
        output mem_store_addr_in, mem_store_ready_in,
        input  store_busy_out, store_done_out,
        input  reg_store_en_out, reg_i_store_loc_out, reg_j_store_loc_out, reg_store_addr_out,
        input  mem_store_en_out, mem_store_element_out, mem_store_last_out,
        input  mem_m_store_size_out, mem_n_store_size_out
    );
endinterface

// File: rtl/mpu_store_stream.sv
// Matrix store streamer: reads an MxN matrix from the register file (1-cycle read latency)
// and emits it to memory one element per beat through a 2-entry buffer with valid/ready.
module mpu_store_stream #(
    parameter int DATA_W = 32,
    parameter int MAX_M  = 8,
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 4
) (
    input logic                clk,
    input logic                rst,
    mpu_store_stream_if.master bus
);
    localparam int M_W = $clog2(MAX_M + 1);
    localparam int N_W = $clog2(MAX_N + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] STREAM  = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]        state, state_next;
    logic [M_W-1:0]    m_size, i_idx;
    logic [N_W-1:0]    n_size, j_idx;
    logic [ADDR_W-1:0] addr;
    logic              transpose;
    logic              in_flight, in_flight_last;
    logic              done, done_next;

    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_next;

    logic start, zero_size, at_last, issue, push, pop;

    assign start     = (state == IDLE) && bus.store_req_in;
    assign zero_size = (bus.reg_m_store_size_in == '0) || (bus.reg_n_store_size_in == '0);
    assign at_last   = (i_idx == M_W'(m_size - 1'b1)) && (j_idx == N_W'(n_size - 1'b1));
    assign push      = in_flight;
    assign pop       = (count != 2'd0) && bus.mem_store_ready_in;

    // Read credit: at most two elements in flight or buffered, unless a beat leaves this cycle
    always_comb begin
        issue = 1'b0;
        if (state == STREAM) begin
            issue = ((2'(in_flight) + count) < 2'd2) || pop;
        end
        count_next = count + 2'(push) - 2'(pop);
    end

    // Next-state and completion pulse
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.store_req_in) begin
                    if (zero_size) done_next  = 1'b1;
                    else           state_next = REQUEST;
                end
            end
            REQUEST: if (bus.store_ready_in) state_next = STREAM;
            STREAM:  if (issue && at_last) state_next = DRAIN;
            DRAIN: begin
                // No reads are issued here, so only the buffer and the last return remain
                if (count_next == 2'd0 && !in_flight) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, request latches and index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            done           <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            m_size         <= '0;
            n_size         <= '0;
            addr           <= '0;
            transpose      <= 1'b0;
            i_idx          <= '0;
            j_idx          <= '0;
        end else begin
            state     <= state_next;
            done      <= done_next;
            in_flight <= issue;
            if (issue) in_flight_last <= at_last;
            if (start) begin
                m_size    <= bus.reg_m_store_size_in;
                n_size    <= bus.reg_n_store_size_in;
                addr      <= bus.mem_store_addr_in;
                transpose <= bus.store_transpose_in;
                i_idx     <= '0;
                j_idx     <= '0;
            end else if (issue && !at_last) begin
                // Counters hold at the final element so they never pass size-1
                if (!transpose) begin
                    if (j_idx == N_W'(n_size - 1'b1)) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end else begin
                    if (i_idx == M_W'(m_size - 1'b1)) begin
                        i_idx <= '0;
                        j_idx <= j_idx + 1'b1;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
            end
        end
    end

    // Two-entry output buffer; returning read data is captured at the end of its cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                fifo_data[k] <= '0;
                fifo_last[k] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.reg_store_element_in;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

    assign bus.reg_store_en_out      = issue;
    assign bus.reg_i_store_loc_out   = i_idx;
    assign bus.reg_j_store_loc_out   = j_idx;
    assign bus.reg_store_addr_out    = addr;
    assign bus.mem_store_en_out      = (count != 2'd0);
    assign bus.mem_store_element_out = fifo_data[rd_ptr];
    assign bus.mem_store_last_out    = (count != 2'd0) && fifo_last[rd_ptr];
    assign bus.mem_m_store_size_out  = m_size;
    assign bus.mem_n_store_size_out  = n_size;
    assign bus.store_busy_out        = (state != IDLE);
    assign bus.store_done_out        = done;
endmodule

// File: tb/tb_mpu_store_stream.sv
// Self-checking bench for mpu_store_stream: expected read order, beat data and timing are
// derived from nested row/column loops over a random matrix held in the bench.
module tb_mpu_store_stream;
    localparam int DATA_W = 32;
    localparam int MAX_M  = 8;
    localparam int MAX_N  = 8;
    localparam int ADDR_W = 4;
    localparam int M_W    = $clog2(MAX_M + 1);
    localparam int N_W    = $clog2(MAX_N + 1);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mpu_store_stream_if #(.DATA_W(DATA_W), .MAX_M(MAX_M), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) bus ();

    mpu_store_stream #(.DATA_W(DATA_W), .MAX_M(MAX_M), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full transfer: issue the request, play the register file and memory, check everything.
    // mode 0: memory always ready (exact timing checked), 1: ready 1,0,0 pattern, 2: random.
    // rdy_delay > 0 holds store_ready_in low that many cycles and fires a stray request meanwhile.
    task automatic run_transfer(input int m, input int n, input bit tr, input int mode,
                                input int rdy_delay);
        logic [DATA_W-1:0] mat [MAX_M][MAX_N];
        int                exp_i [$];
        int                exp_j [$];
        logic [DATA_W-1:0] exp_d [$];
        int                total, reads, beats, last_hs, ii, jj;
        bit                pend, was_stalled, finished;
        logic [DATA_W-1:0] pend_d, held_d;
        logic [ADDR_W-1:0] addr;
        total = m * n; reads = 0; beats = 0; last_hs = -1;
        pend = 0; was_stalled = 0; finished = 0; pend_d = '0; held_d = '0;
        addr = ADDR_W'($urandom);
        for (int i = 0; i < MAX_M; i++)
            for (int j = 0; j < MAX_N; j++) mat[i][j] = DATA_W'($urandom);
        if (!tr) begin
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j++) begin
                    exp_i.push_back(i); exp_j.push_back(j); exp_d.push_back(mat[i][j]);
                end
        end else begin
            for (int j = 0; j < n; j++)
                for (int i = 0; i < m; i++) begin
                    exp_i.push_back(i); exp_j.push_back(j); exp_d.push_back(mat[i][j]);
                end
        end

        @(negedge clk);
        bus.store_req_in        = 1'b1;
        bus.store_transpose_in  = tr;
        bus.reg_m_store_size_in = M_W'(m);
        bus.reg_n_store_size_in = N_W'(n);
        bus.mem_store_addr_in   = addr;
        bus.store_ready_in      = 1'b0;
        bus.mem_store_ready_in  = 1'b1;

        for (int cyc = 1; cyc <= 800 && !finished; cyc++) begin
            @(negedge clk);
            bus.store_req_in        = (rdy_delay > 0 && cyc == 2);
            bus.store_transpose_in  = 1'($urandom);
            bus.reg_m_store_size_in = M_W'($urandom_range(1, MAX_M));
            bus.reg_n_store_size_in = N_W'($urandom_range(1, MAX_N));
            bus.mem_store_addr_in   = ADDR_W'($urandom);
            bus.store_ready_in      = (cyc > rdy_delay);
            case (mode)
                0:       bus.mem_store_ready_in = 1'b1;
                1:       bus.mem_store_ready_in = (cyc % 3 == 0);
                default: bus.mem_store_ready_in = 1'($urandom_range(0, 1));
            endcase
            bus.reg_store_element_in = pend ? pend_d : DATA_W'($urandom);
            pend = 0;
            #1;

            checks++;
            if (bus.store_done_out) begin
                finished = 1;
                if (beats != total || cyc != last_hs + 1 || bus.store_busy_out !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: cyc %0d beats %0d busy %b, expected cyc %0d beats %0d busy 0",
                             cyc, beats, bus.store_busy_out, last_hs + 1, total);
                end
            end else if (bus.store_busy_out !== 1'b1) begin
                errors++;
                $display("FAIL busy: got %b at cyc %0d, expected 1", bus.store_busy_out, cyc);
            end

            checks++;
            if (bus.reg_store_addr_out !== addr || bus.mem_m_store_size_out !== M_W'(m) ||
                bus.mem_n_store_size_out !== N_W'(n)) begin
                errors++;
                $display("FAIL latched: got addr %0d m %0d n %0d, expected addr %0d m %0d n %0d",
                         bus.reg_store_addr_out, bus.mem_m_store_size_out,
                         bus.mem_n_store_size_out, addr, m, n);
            end

            if (bus.reg_store_en_out) begin
                ii = int'(bus.reg_i_store_loc_out);
                jj = int'(bus.reg_j_store_loc_out);
                checks++;
                if (reads >= total) begin
                    errors++;
                    $display("FAIL read_extra: read (%0d,%0d) at cyc %0d, expected only %0d reads",
                             ii, jj, cyc, total);
                end else if (ii != exp_i[reads] || jj != exp_j[reads] ||
                             (mode == 0 && cyc != 2 + rdy_delay + reads)) begin
                    errors++;
                    $display("FAIL read_order: got (%0d,%0d) cyc %0d, expected (%0d,%0d) read %0d",
                             ii, jj, cyc, exp_i[reads], exp_j[reads], reads);
                end
                pend   = 1;
                pend_d = (ii < m && jj < n) ? mat[ii][jj] : '0;
                reads++;
            end

            if (was_stalled) begin
                checks++;
                if (bus.mem_store_en_out !== 1'b1 || bus.mem_store_element_out !== held_d) begin
                    errors++;
                    $display("FAIL stall_hold: got en %b data %h, expected en 1 data %h",
                             bus.mem_store_en_out, bus.mem_store_element_out, held_d);
                end
            end
            was_stalled = 0;

            if (bus.mem_store_en_out) begin
                checks++;
                if (beats >= total) begin
                    errors++;
                    $display("FAIL beat_extra: beat %h at cyc %0d, expected only %0d beats",
                             bus.mem_store_element_out, cyc, total);
                end else if (bus.mem_store_element_out !== exp_d[beats] ||
                             bus.mem_store_last_out !== (beats == total - 1) ||
                             (mode == 0 && cyc != 4 + rdy_delay + beats)) begin
                    errors++;
                    $display("FAIL beat: got %h last %b cyc %0d, expected %h last %b beat %0d",
                             bus.mem_store_element_out, bus.mem_store_last_out, cyc,
                             exp_d[beats], (beats == total - 1), beats);
                end
                if (bus.mem_store_ready_in) begin
                    beats++;
                    last_hs = cyc;
                end else begin
                    was_stalled = 1;
                    held_d      = bus.mem_store_element_out;
                end
            end

            checks++;
            if (reads - beats > 2 || (!bus.mem_store_en_out && bus.mem_store_last_out)) begin
                errors++;
                $display("FAIL occupancy: got %0d outstanding, last %b en %b, expected <=2 and no idle last",
                         reads - beats, bus.mem_store_last_out, bus.mem_store_en_out);
            end
        end

        checks++;
        if (!finished || reads != total || beats != total) begin
            errors++;
            $display("FAIL transfer_end: got done %b reads %0d beats %0d, expected done 1 and %0d each",
                     finished, reads, beats, total);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (bus.store_busy_out !== 1'b0 || bus.store_done_out !== 1'b0 ||
            bus.reg_store_en_out !== 1'b0 || bus.mem_store_en_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy %b done %b ren %b men %b, expected all 0",
                     bus.store_busy_out, bus.store_done_out, bus.reg_store_en_out,
                     bus.mem_store_en_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.store_busy_out !== 1'b0 || bus.mem_store_last_out !== 1'b0 ||
            bus.reg_store_addr_out !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b last %b addr %0d, expected 0 0 0",
                     bus.store_busy_out, bus.mem_store_last_out, bus.reg_store_addr_out);
        end
    endtask

    task automatic test_row_major();
        run_transfer(2, 3, 1'b0, 0, 0);
    endtask

    task automatic test_transpose();
        run_transfer(2, 3, 1'b1, 0, 0);
    endtask

    task automatic test_stall();
        run_transfer(3, 3, 1'b0, 1, 0);
        run_transfer(3, 3, 1'b1, 1, 0);
    endtask

    task automatic test_zero_size();
        int ms [2];
        int ns [2];
        ms[0] = 0; ns[0] = 4;
        ms[1] = 3; ns[1] = 0;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.store_req_in        = 1'b1;
            bus.reg_m_store_size_in = M_W'(ms[t]);
            bus.reg_n_store_size_in = N_W'(ns[t]);
            bus.store_ready_in      = 1'b1;
            bus.mem_store_ready_in  = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                bus.store_req_in = 1'b0;
                #1;
                checks++;
                if (bus.store_done_out !== (c == 1) || bus.store_busy_out !== 1'b0 ||
                    bus.reg_store_en_out !== 1'b0 || bus.mem_store_en_out !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_size: %0dx%0d cyc %0d got done %b busy %b ren %b men %b, expected done %b rest 0",
                             ms[t], ns[t], c, bus.store_done_out, bus.store_busy_out,
                             bus.reg_store_en_out, bus.mem_store_en_out, (c == 1));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.store_req_in        = 1'b1;
        bus.store_transpose_in  = 1'b0;
        bus.reg_m_store_size_in = M_W'(4);
        bus.reg_n_store_size_in = N_W'(4);
        bus.mem_store_addr_in   = ADDR_W'(9);
        bus.store_ready_in      = 1'b1;
        bus.mem_store_ready_in  = 1'b1;
        @(negedge clk);
        bus.store_req_in = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.store_busy_out !== 1'b1 || bus.reg_store_en_out !== 1'b1 ||
            bus.mem_store_en_out !== 1'b1) begin
            errors++;
            $display("FAIL midstream: got busy %b ren %b men %b, expected 1 1 1",
                     bus.store_busy_out, bus.reg_store_en_out, bus.mem_store_en_out);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.store_busy_out !== 1'b0 || bus.reg_store_en_out !== 1'b0 ||
            bus.mem_store_en_out !== 1'b0 || bus.mem_store_last_out !== 1'b0 ||
            bus.store_done_out !== 1'b0 || bus.reg_store_addr_out !== '0 ||
            bus.mem_m_store_size_out !== '0 || bus.mem_n_store_size_out !== '0 ||
            bus.reg_i_store_loc_out !== '0 || bus.reg_j_store_loc_out !== '0 ||
            bus.mem_store_element_out !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy %b ren %b men %b done %b addr %0d, expected all 0",
                     bus.store_busy_out, bus.reg_store_en_out, bus.mem_store_en_out,
                     bus.store_done_out, bus.reg_store_addr_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.store_done_out !== 1'b0 || bus.store_busy_out !== 1'b0) begin
                errors++;
                $display("FAIL post_reset: got done %b busy %b, expected 0 0",
                         bus.store_done_out, bus.store_busy_out);
            end
        end
        run_transfer(1, 1, 1'b0, 0, 0);
    endtask

    task automatic test_busy_ignored();
        run_transfer(2, 2, 1'b0, 0, 5);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_transfer($urandom_range(1, MAX_M), $urandom_range(1, MAX_N),
                         1'($urandom), (t == 0) ? 0 : 2, (t % 3 == 0) ? 2 : 0);
        end
    endtask

    task automatic test_back_to_back();
        run_transfer(MAX_M, MAX_N, 1'b1, 0, 0);
        run_transfer(1, MAX_N, 1'b0, 0, 0);
        run_transfer(MAX_M, 1, 1'b0, 2, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.store_req_in         = 1'b0;
        bus.store_transpose_in   = 1'b0;
        bus.store_ready_in       = 1'b0;
        bus.reg_m_store_size_in  = '0;
        bus.reg_n_store_size_in  = '0;
        bus.reg_store_element_in = '0;
        bus.mem_store_addr_in    = '0;
        bus.mem_store_ready_in   = 1'b0;

        test_reset();
        test_row_major();
        test_transpose();
        test_stall();
        test_zero_size();
        test_async_reset();
        test_busy_ignored();
        test_random();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
